// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: drains a 1-cycle-latency FIFO into a 2-entry skid buffer
// and presents it as a valid/ready stream. Optional transfer counter: FIFO_RD_CTRL_CNT_EN.
module fifo_rd_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_underflow,
    output logic             fifo_rd_en,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic             err,
    output logic [15:0]      xfer_cnt
);

    logic [1:0]       occ_q;
    logic             infl_q;
    logic [WIDTH-1:0] buf_q [2];
    logic             rd_idx_q;
    logic             wr_idx_q;
    logic             err_q;
    logic             pop;
    // Occupancy after this edge; occ + infl never exceeds 2, so two bits suffice.
    logic [1:0]       level;

    always_comb begin
        pop        = m_valid && m_ready;
        level      = occ_q + {1'b0, infl_q} - {1'b0, pop};
        fifo_rd_en = rst_n && !fifo_empty && (level < 2'd2);
    end

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = buf_q[rd_idx_q];
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q    <= 2'd0;
            infl_q   <= 1'b0;
            rd_idx_q <= 1'b0;
            wr_idx_q <= 1'b0;
            err_q    <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            occ_q  <= level;
            infl_q <= fifo_rd_en;
            if (infl_q) begin
                buf_q[wr_idx_q] <= fifo_dout;
                wr_idx_q        <= ~wr_idx_q;
            end
            if (pop) begin
                rd_idx_q <= ~rd_idx_q;
            end
            // Underflow only matters when we actually expected a word this cycle.
            if (fifo_underflow && infl_q) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef FIFO_RD_CTRL_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else if (pop) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign xfer_cnt = cnt_q;
`else
    assign xfer_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed self-checking bench for fifo_rd_ctrl with a behavioural 1-cycle-latency FIFO.
module tb_fifo_rd_ctrl;

    localparam int W = 8;

    logic         clk            = 1'b0;
    logic         rst_n          = 1'b0;
    logic         fifo_empty     = 1'b1;
    logic [W-1:0] fifo_dout      = '0;
    logic         fifo_underflow = 1'b0;
    logic         m_ready        = 1'b0;
    logic         fifo_rd_en;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         err;
    logic [15:0]  xfer_cnt;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] got[$];
    int n_pops  = 0;
    int max_occ = 0;

    always #5 clk = ~clk;

    fifo_rd_ctrl #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_empty     (fifo_empty),
        .fifo_dout      (fifo_dout),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .err            (err),
        .xfer_cnt       (xfer_cnt)
    );

    // Behavioural FIFO: registered read data and registered empty flag.
    always @(posedge clk) begin
        if (fifo_rd_en && q.size() > 0) fifo_dout <= q.pop_front();
        fifo_empty <= (q.size() == 0);
    end

    always @(negedge clk) begin
        if (!rst_n) n_pops = 0;
        else if (m_valid && m_ready) begin
            got.push_back(m_data);
            n_pops++;
        end
        if (int'(dut.occ_q) > max_occ) max_occ = int'(dut.occ_q);
    end

    function automatic logic [15:0] cnt_exp();
`ifdef FIFO_RD_CTRL_CNT_EN
        return n_pops[15:0];
`else
        return 16'd0;
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        q.push_back(8'h99);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", m_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %h want 0000", xfer_cnt); end
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [6:0]   exp_rd;
        logic [6:0]   exp_v;
        logic [W-1:0] exp_d [7];
        exp_rd = 7'b0001110;
        exp_v  = 7'b0111000;
        exp_d  = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        m_ready = 1'b1;
        got.delete();
        @(posedge clk); #1;
        q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk); #1;
            checks++; if (fifo_rd_en !== exp_rd[c]) begin errors++; $display("FAIL basic_rd_en c%0d: got %b want %b", c, fifo_rd_en, exp_rd[c]); end
            checks++; if (m_valid !== exp_v[c]) begin errors++; $display("FAIL basic_valid c%0d: got %b want %b", c, m_valid, exp_v[c]); end
            if (exp_v[c]) begin
                checks++; if (m_data !== exp_d[c]) begin errors++; $display("FAIL basic_data c%0d: got %h want %h", c, m_data, exp_d[c]); end
            end
        end
        checks++; if (xfer_cnt !== cnt_exp()) begin errors++; $display("FAIL basic_cnt: got %h want %h", xfer_cnt, cnt_exp()); end
    endtask

    task automatic test_stall();
        int pulses = 0;
        m_ready = 1'b0;
        got.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) q.push_back(8'hA0 + 8'(i));
        for (int c = 0; c < 11; c++) begin
            @(negedge clk); #1;
            if (fifo_rd_en) pulses++;
            if (c >= 3) begin
                checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c%0d: got %b want 1", c, m_valid); end
                checks++; if (m_data !== 8'hA0) begin errors++; $display("FAIL stall_hold c%0d: got %h want a0", c, m_data); end
            end
        end
        checks++; if (pulses != 2) begin errors++; $display("FAIL stall_rd_pulses: got %0d want 2", pulses); end
        @(posedge clk); #1;
        m_ready = 1'b1;
        for (int i = 0; i < 30 && got.size() < 5; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #1;
        checks++; if (got.size() != 5) begin errors++; $display("FAIL stall_count: got %0d want 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            checks++; if (got[i] !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL stall_order %0d: got %h want %h", i, got[i], 8'hA0 + 8'(i)); end
        end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stall_drained: got %b want 0", m_valid); end
    endtask

    task automatic test_toggle();
        got.delete();
        max_occ = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) q.push_back(8'(i));
        m_ready = 1'b1;
        for (int i = 0; i < 80 && got.size() < 16; i++) begin
            @(posedge clk); #1;
            m_ready = ~m_ready;
        end
        m_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (got.size() != 16) begin errors++; $display("FAIL toggle_count: got %0d want 16", got.size()); end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            checks++; if (got[i] !== 8'(i)) begin errors++; $display("FAIL toggle_order %0d: got %h want %h", i, got[i], 8'(i)); end
        end
        checks++; if (max_occ > 2) begin errors++; $display("FAIL toggle_occ: got %0d want <=2", max_occ); end
    endtask

    task automatic test_empty();
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            // Underflow with no read in flight must not flag an error.
            fifo_underflow = (c == 3);
            @(negedge clk); #1;
            checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL empty_rd_en c%0d: got %b want 0", c, fifo_rd_en); end
            checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL empty_valid c%0d: got %b want 0", c, m_valid); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL empty_err c%0d: got %b want 0", c, err); end
        end
        fifo_underflow = 1'b0;
    endtask

    task automatic test_reset_inflight();
        m_ready = 1'b0;
        got.delete();
        @(posedge clk); #1;
        q.push_back(8'h71); q.push_back(8'h72);
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rif_pre_valid: got %b want 1", m_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rif_valid: got %b want 0", m_valid); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rif_rd_en: got %b want 0", fifo_rd_en); end
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rif_idle c%0d: got %b want 0", c, m_valid); end
        end
        checks++; if (got.size() != 0) begin errors++; $display("FAIL rif_nothing: got %0d want 0", got.size()); end
        @(posedge clk); #1;
        q.push_back(8'h5A);
        for (int i = 0; i < 20 && got.size() < 1; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (got.size() != 1) begin errors++; $display("FAIL rif_new_count: got %0d want 1", got.size()); end
        else begin
            checks++; if (got[0] !== 8'h5A) begin errors++; $display("FAIL rif_new_data: got %h want 5a", got[0]); end
        end
        checks++; if (xfer_cnt !== cnt_exp()) begin errors++; $display("FAIL rif_cnt: got %h want %h", xfer_cnt, cnt_exp()); end
    endtask

    task automatic test_underflow();
        m_ready = 1'b1;
        @(posedge clk); #1;
        q.push_back(8'hC3);
        @(posedge clk); #1;
        @(negedge clk); #1;
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL uf_rd_en: got %b want 1", fifo_rd_en); end
        @(posedge clk); #1;
        fifo_underflow = 1'b1;
        @(negedge clk); #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL uf_err_early: got %b want 0", err); end
        @(posedge clk); #1;
        fifo_underflow = 1'b0;
        @(negedge clk); #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL uf_err_set: got %b want 1", err); end
        repeat (5) @(negedge clk);
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL uf_err_sticky: got %b want 1", err); end
    endtask

    task automatic test_wrap_and_clear();
        rst_n = 1'b0;
        q.delete();
        @(posedge clk); #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL clear_err: got %b want 0", err); end
        rst_n = 1'b1;
`ifdef FIFO_RD_CTRL_CNT_EN
        got.delete();
        m_ready = 1'b1;
        for (int i = 0; i < 65536; i++) q.push_back(8'(i));
        for (int i = 0; i < 70000 && n_pops < 65536; i++) @(negedge clk);
        got.delete();
        repeat (4) @(negedge clk);
        #1;
        checks++; if (n_pops != 65536) begin errors++; $display("FAIL wrap_pops: got %0d want 65536", n_pops); end
        checks++; if (xfer_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_cnt: got %h want 0000", xfer_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_toggle();
        test_empty();
        test_reset_inflight();
        test_underflow();
        test_wrap_and_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
